// File: rtl/io_uart_pkg.sv
// Shared definitions for the UART byte bridge: FSM encodings, io_err bit map, default bit timing.
package io_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    localparam int unsigned ERR_FRAME   = 0;
    localparam int unsigned ERR_OVERRUN = 1;
    localparam int unsigned ERR_BREAK   = 2;
    localparam int unsigned ERR_RXFULL  = 3;
    localparam int unsigned ERR_TXFULL  = 4;
    localparam int unsigned ERR_W       = 5;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitHigh
    } rx_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

endpackage

// File: rtl/io_uart_bridge_if.sv
// Core-side byte channel: rx producer, tx consumer and error flags.
interface io_uart_bridge_if;

    logic [7:0]                    io_in_data;
    logic                          io_in_vld;
    logic                          io_in_rdy;
    logic [7:0]                    io_out_data;
    logic                          io_out_vld;
    logic                          io_out_rdy;
    logic [io_uart_pkg::ERR_W-1:0] io_err;

    // Core side.
    modport master (
        input  io_in_data,
        input  io_in_vld,
        output io_in_rdy,
        output io_out_data,
        output io_out_vld,
        input  io_out_rdy,
        input  io_err
    );

    // Bridge side.
    modport slave (
        output io_in_data,
        output io_in_vld,
        input  io_in_rdy,
        input  io_out_data,
        input  io_out_vld,
        output io_out_rdy,
        output io_err
    );

endinterface

// File: rtl/io_byte_fifo.sv
// First-word-fall-through byte FIFO; dout reads 0 while empty.
module io_byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [7:0]                  din,
    input  logic                        pop,
    output logic [7:0]                  dout,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = {1'b1, {PW{1'b0}}};

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // A simultaneous pop frees the slot, so a full FIFO may still take a push.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == FULL_CNT);
        do_pop  = pop && !empty;
        do_push = push && (!full || pop);
        dout    = empty ? 8'h00 : mem[rd_ptr_q];
        count   = count_q;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/io_uart_bridge.sv
// UART <-> core byte channel bridge with rx/tx FIFOs and error reporting.
module io_uart_bridge
    import io_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    output logic             uart_tx,
    io_uart_bridge_if.slave  io
);

    localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   FULL_CNT  = {1'b1, {PW{1'b0}}};

    logic            rx_meta_q;
    logic            rx_sync_q;
    rx_state_e       rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic            err_frame_q;
    logic            err_overrun_q;
    logic            err_break_q;

    tx_state_e       tx_state_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_shift_q;
    logic            tx_q;

    logic            rx_push;
    logic            rx_pop;
    logic            rx_overrun;
    logic [7:0]      rx_dout;
    logic            rx_empty;
    logic            rx_full;
    logic [PW:0]     rx_count;

    logic            tx_push;
    logic            tx_pop;
    logic [7:0]      tx_dout;
    logic            tx_empty;
    logic            tx_full;
    logic [PW:0]     tx_count;

    io_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_shift_q),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    io_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (io.io_out_data),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    // Handshakes, FIFO strobes and core-facing outputs.
    always_comb begin
        rx_pop     = !rx_empty && io.io_in_rdy;
        rx_push    = (rx_state_q == RxStop) && (rx_cnt_q == BIT_LAST) && rx_sync_q;
        rx_overrun = rx_push && (rx_count == FULL_CNT) && !rx_pop;
        tx_push    = io.io_out_vld && !tx_full;
        // The shifter reloads straight from STOP so back-to-back frames have no idle gap.
        tx_pop     = !tx_empty &&
                     ((tx_state_q == TxIdle) ||
                      ((tx_state_q == TxStop) && (tx_cnt_q == BIT_LAST)));

        io.io_in_data  = rx_dout;
        io.io_in_vld   = !rx_empty;
        io.io_out_rdy  = !tx_full;
        io.io_err              = '0;
        io.io_err[ERR_FRAME]   = err_frame_q;
        io.io_err[ERR_OVERRUN] = err_overrun_q;
        io.io_err[ERR_BREAK]   = err_break_q;
        io.io_err[ERR_RXFULL]  = rx_full;
        io.io_err[ERR_TXFULL]  = (tx_count == FULL_CNT);
        uart_tx        = tx_q;
    end

    // Two-flop synchroniser for the asynchronous rx line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receive FSM: mid-bit sampling, stop-bit validation and sticky error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= RxIdle;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_break_q   <= 1'b0;
        end else begin
            unique case (rx_state_q)
                RxIdle: begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    if (!rx_sync_q) rx_state_q <= RxStart;
                end
                RxStart: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        // A start bit that has vanished by mid-bit is a glitch.
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        if (rx_sync_q) begin
                            if (rx_overrun) err_overrun_q <= 1'b1;
                            rx_state_q <= RxIdle;
                        end else begin
                            err_frame_q <= 1'b1;
                            if (rx_shift_q == 8'h00) err_break_q <= 1'b1;
                            rx_state_q <= RxWaitHigh;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxWaitHigh: begin
                    if (rx_sync_q) rx_state_q <= RxIdle;
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // Transmit FSM: start, eight data bits LSB first, stop; line level is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    tx_cnt_q <= '0;
                    tx_bit_q <= '0;
                    if (!tx_empty) begin
                        tx_shift_q <= tx_dout;
                        tx_q       <= 1'b0;
                        tx_state_q <= TxStart;
                    end
                end
                TxStart: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_state_q <= TxData;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxData: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        tx_bit_q <= tx_bit_q + 1'b1;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TxStop;
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxStop: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (!tx_empty) begin
                            tx_shift_q <= tx_dout;
                            tx_q       <= 1'b0;
                            tx_state_q <= TxStart;
                        end else begin
                            tx_state_q <= TxIdle;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_bridge.sv
// Self-checking bench for io_uart_bridge with a frame-level reference model.
module tb_io_uart_bridge;
    import io_uart_pkg::*;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FW    = 10 * CPB;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;

    io_uart_bridge_if bus ();

    io_uart_bridge #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .io      (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: expected rx FIFO contents and sticky flags.
    logic [7:0] rx_q [$];
    bit m_frm = 0;
    bit m_ovr = 0;
    bit m_brk = 0;

    // uart_tx waveform log, sampled on the falling edge.
    bit rec_on = 0;
    bit tx_log [$];
    always @(negedge clk) if (rec_on) tx_log.push_back(uart_tx);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] exp_err(input bit txfull);
        logic [4:0] e;
        e              = '0;
        e[ERR_FRAME]   = m_frm;
        e[ERR_OVERRUN] = m_ovr;
        e[ERR_BREAK]   = m_brk;
        e[ERR_RXFULL]  = (rx_q.size() == DEPTH);
        e[ERR_TXFULL]  = txfull;
        return e;
    endfunction

    // Drive one UART frame; extra_low keeps a bad stop bit low for longer.
    task automatic rx_frame(input logic [7:0] b, input bit stop, input int extra_low);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx = f[k];
            repeat (CPB) tick();
        end
        repeat (extra_low) tick();
        uart_rx = 1'b1;
        repeat (4) tick();
        if (stop) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(b);
            else m_ovr = 1;
        end else begin
            m_frm = 1;
            if (b == 8'h00) m_brk = 1;
        end
    endtask

    task automatic rx_check(input string tag);
        check_eq({tag, "_vld"}, bus.io_in_vld, rx_q.size() > 0);
        check_eq({tag, "_data"}, bus.io_in_data, (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        check_eq({tag, "_err"}, bus.io_err, exp_err(1'b0));
    endtask

    task automatic rx_read();
        bus.io_in_rdy = 1'b1;
        tick();
        bus.io_in_rdy = 1'b0;
        if (rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    function automatic int first_low();
        for (int i = 0; i < tx_log.size(); i++) if (!tx_log[i]) return i;
        return -1;
    endfunction

    task automatic tx_wave_check(input string tag, input int start, input logic [7:0] b);
        logic [9:0]    f;
        logic [FW-1:0] obs;
        logic [FW-1:0] expw;
        f = {1'b1, b, 1'b0};
        for (int j = 0; j < FW; j++) begin
            expw[j] = f[j / CPB];
            obs[j]  = (start >= 0 && start + j < tx_log.size()) ? tx_log[start + j] : 1'bx;
        end
        check_eq(tag, obs, expw);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic [7:0] b3 [5];
        int occ;
        int acc;
        int fl;
        bit exp_rdy;

        bus.io_in_rdy   = 1'b0;
        bus.io_out_vld  = 1'b0;
        bus.io_out_data = 8'h00;

        // Reset state, both while held and after release.
        repeat (3) tick();
        check_eq("rst_tx", uart_tx, 1'b1);
        check_eq("rst_in_vld", bus.io_in_vld, 1'b0);
        check_eq("rst_in_data", bus.io_in_data, 8'h00);
        check_eq("rst_out_rdy", bus.io_out_rdy, 1'b1);
        check_eq("rst_err", bus.io_err, 5'h00);
        rst = 1'b0;
        repeat (4) tick();
        check_eq("post_rst_tx", uart_tx, 1'b1);

        // Single rx frame held until the core reads it.
        rx_frame(8'h5A, 1'b1, 0);
        rx_check("rx5a");
        rx_read();
        rx_check("rx5a_read");

        // Random rx bytes, each read back.
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_frame(b, 1'b1, 0);
            rx_check("rx_rand");
            rx_read();
            rx_check("rx_rand_read");
        end

        // Single tx frames: fixed 0xA5 then random bytes.
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            tx_log.delete();
            rec_on          = 1;
            bus.io_out_vld  = 1'b1;
            bus.io_out_data = b;
            tick();
            bus.io_out_vld  = 1'b0;
            repeat (FW + 4) tick();
            rec_on = 0;
            fl = first_low();
            check_eq("tx_start_lat", fl, 2);
            tx_wave_check("tx_frame", fl, b);
            check_eq("tx_idle_after", uart_tx, 1'b1);
        end

        // Back-to-back pushes until full; the first frame's pop frees one slot.
        for (int i = 0; i < 5; i++) b3[i] = 8'($urandom_range(0, 255));
        occ = 0;
        acc = 0;
        tx_log.delete();
        rec_on = 1;
        for (int i = 0; i < 20 && acc < 5; i++) begin
            exp_rdy = (occ < DEPTH);
            check_eq("burst_rdy", bus.io_out_rdy, exp_rdy);
            check_eq("burst_txfull", bus.io_err[ERR_TXFULL], !exp_rdy);
            bus.io_out_vld  = 1'b1;
            bus.io_out_data = b3[acc];
            tick();
            if (exp_rdy) begin
                occ++;
                acc++;
            end
            if (i == 1) occ--;
        end
        bus.io_out_vld = 1'b0;
        check_eq("burst_full_rdy", bus.io_out_rdy, occ < DEPTH);
        check_eq("burst_full_flag", bus.io_err[ERR_TXFULL], occ == DEPTH);
        repeat (5 * FW + 10) tick();
        rec_on = 0;
        fl = first_low();
        check_eq("burst_start_lat", fl, 2);
        for (int i = 0; i < 5; i++) tx_wave_check("burst_frame", fl + i * FW, b3[i]);
        check_eq("burst_idle_tx", uart_tx, 1'b1);
        check_eq("burst_idle_rdy", bus.io_out_rdy, 1'b1);

        // Overrun: five frames into a four-deep FIFO with no reads.
        for (int i = 0; i < 5; i++) begin
            rx_frame(8'($urandom_range(0, 255)), 1'b1, 0);
            rx_check("ovr_fill");
        end
        rx_read();
        rx_check("ovr_read1");
        while (rx_q.size() > 0) begin
            rx_read();
            rx_check("ovr_drain");
        end

        // Break: zero data with a low stop bit, line held low, then a good frame.
        rx_frame(8'h00, 1'b0, 3 * CPB);
        rx_check("brk");
        rx_frame(8'h33, 1'b1, 0);
        rx_check("brk_then_33");
        rx_read();
        rx_check("brk_then_33_read");

        // One-cycle glitch on the rx line.
        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        repeat (20) tick();
        rx_check("glitch");

        // Reset in the middle of a tx frame of zeros.
        bus.io_out_vld  = 1'b1;
        bus.io_out_data = 8'h00;
        tick();
        bus.io_out_vld  = 1'b0;
        repeat (10) tick();
        check_eq("midrst_busy", uart_tx, 1'b0);
        rst = 1'b1;
        tick();
        rx_q.delete();
        m_frm = 0;
        m_ovr = 0;
        m_brk = 0;
        check_eq("midrst_tx", uart_tx, 1'b1);
        check_eq("midrst_rdy", bus.io_out_rdy, 1'b1);
        check_eq("midrst_err", bus.io_err, exp_err(1'b0));
        check_eq("midrst_vld", bus.io_in_vld, 1'b0);
        rst = 1'b0;
        repeat (FW + 10) tick();
        check_eq("midrst_no_resume", uart_tx, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
